pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central sequencer for the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Inputs: memory handshakes (ihit, dhit), hazard information from ID/EX, and control-flow resolution from ID/MEM.
- Outputs: per-latch enable and flush, plus PC enable and select.
- Tracks data-memory wait and halt in a small FSM.
- Keeps stall and flush performance counters.

Parameters:
- CNT_W, 32, width of stall_count and flush_count
- REG_W, 5, register-index width

Ports:
- CLK  in  1  clock; all state updates on the posedge
- RST  in  1  reset, synchronous, active-high
- ihit  in  1  instruction fetch valid this cycle
- dhit  in  1  data access complete this cycle
- dmem_req  in  1  MEM stage holds a load or store
- branch_taken  in  1  branch resolved taken in MEM
- jump_id  in  1  jump decoded in ID
- halt_mem  in  1  halt instruction in MEM
- ex_memread  in  1  EX stage holds a load
- ex_rd  in  REG_W  EX-stage destination register
- id_rs  in  REG_W  ID source register rs
- id_rt  in  REG_W  ID source register rt
- pc_en  out  1  PC update enable
- pc_sel  out  2  00 sequential, 01 jump target, 10 branch target
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  latch enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  latch clear; flush has priority over en at the latch
- halted  out  1  pipeline halted
- state  out  2  current FSM state
- stall_count  out  CNT_W  stall cycles
- flush_count  out  CNT_W  control-flow flushes

Behaviour:
- Reset is synchronous and active-high.
  - Registered state on the cycle after RST=1: state=RUN, halted=0, both counters 0.
  - While RST=1, the combinational outputs are forced: all enables 0, all flushes 0, pc_en=0, pc_sel=00.
- FSM states: RUN=00, DWAIT=01, HALT=10.
- All control outputs are combinational from state and inputs; there is zero-cycle latency from input to control.
- RUN: evaluate in strict priority order; the first match wins.
  1. halt_mem=1: mem_wb_en=1; all other en=0; pc_en=0; next state HALT.
  2. dmem_req & ~dhit: all en=0; pc_en=0; next state DWAIT.
  3. branch_taken: all en=1; pc_en=1; pc_sel=10; if_id_flush, id_ex_flush and ex_mem_flush=1; flush_count+1.
  4. Load-use: ex_memread & (ex_rd!=0) & (ex_rd==id_rs | ex_rd==id_rt). Then pc_en=0, if_id_en=0, id_ex_flush=1, remaining en=1.
  5. jump_id: all en=1; pc_en=1; pc_sel=01; if_id_flush=1; flush_count+1.
  6. ~ihit: pc_en=0; if_id_flush=1 (bubble); remaining en=1.
  7. Otherwise: all en=1, pc_en=1, pc_sel=00, no flush.
- DWAIT:
  - dhit=0: everything frozen (all en=0, pc_en=0).
  - dhit=1: evaluate the RUN rules as if the data access were already complete (rule 2 cannot fire); next state RUN.
  - halt_mem during DWAIT is taken only on the dhit cycle, via rule 1.
- HALT:
  - Absorbing until RST; halted=1.
  - All en=0, all flush=0, pc_en=0.
  - Counters hold.
- stall_count increments on every non-reset cycle where pc_en=0 and the state is RUN or DWAIT.
  - This includes halt-entry and dmem freeze cycles.
- Counters wrap modulo 2^CNT_W; no saturation.
- Simultaneous events:
  - A branch and a load-use hazard in the same cycle: the branch wins and the load-use instruction is flushed.
  - A branch and ~ihit in the same cycle: the branch wins; the IF/ID flush already covers the bubble.
- Reset asserted mid-DWAIT: returns to RUN on the next edge with counters 0.

Decomposition:
- Additions to cpu_types_pkg:
  - typedef enum logic [1:0] pctrl_state_t {RUN, DWAIT, HALT}
  - typedef enum logic [1:0] pcsel_t {PC_SEQ, PC_JUMP, PC_BRANCH}
- Sub-module hazard_unit: a purely combinational load-use compare. Inputs ex_memread, ex_rd, id_rs, id_rt; output lu_hazard.
- The FSM, priority logic and counters stay in pipeline_ctrl.

Test Plan:
- Reset and idle: RST=1 for 2 cycles, then ihit=1 with all other inputs 0 → all en=1, pc_en=1, pc_sel=00, state=00, counters 0.
- Data-memory wait: dmem_req=1, dhit=0 for 3 cycles, then dhit=1.
  - Frozen cycles: all en=0, state=01.
  - dhit cycle: all en=1; next state=00.
  - stall_count=3.
- Load-use: ex_memread=1, ex_rd=8, id_rt=8 → pc_en=0, if_id_en=0, id_ex_flush=1, stall_count+1. Repeat with ex_rd=0 → no stall.
- Branch beats load-use: branch_taken=1 together with a load-use match → pc_sel=10; three flushes; flush_count=1; stall_count unchanged.
- Halt: halt_mem=1 → mem_wb_en=1 that cycle; next state=10 and halted=1. It stays halted through 5 cycles of arbitrary inputs, and RST=1 returns it to RUN.
- Counter wrap: with CNT_W=4, apply 17 load-use cycles → stall_count=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control slice: sequencer states and PC select codes.
package cpu_types_pkg;

  // Pipeline sequencer states (encoding is visible on the state debug output).
  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DWAIT = 2'b01,
    HALT  = 2'b10
  } pctrl_state_t;

  // PC source select.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_JUMP   = 2'b01,
    PC_BRANCH = 2'b10
  } pcsel_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detect: the load in EX writes a register that the
// instruction in ID reads. Register 0 is hard-wired, so it never conflicts.
module hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             lu_hazard
);

  // Purely combinational compare of the EX destination against both ID sources.
  always_comb begin
    lu_hazard = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the pipeline latches and the PC register.
//
// Handshakes: ihit is the fetch "valid" -- when low there is no instruction
// to latch into IF/ID, so a bubble is inserted and the PC holds. dhit is the
// data-memory "ready" for a request signalled by dmem_req -- while dmem_req=1
// and dhit=0 the whole pipeline freezes; the cycle with dhit=1 completes the
// access and the pipeline advances in that same cycle.
module pipeline_ctrl #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req,
  input  logic             branch_taken,
  input  logic             jump_id,
  input  logic             halt_mem,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  import cpu_types_pkg::*;

  pctrl_state_t state_q;
  pctrl_state_t state_d;
  pcsel_t       pc_sel_d;
  logic         lu_hazard;
  logic         stall_inc;
  logic         flush_inc;

  hazard_unit #(.REG_W(REG_W)) u_hazard (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .lu_hazard  (lu_hazard)
  );

  assign state  = state_q;
  assign pc_sel = pc_sel_d;
  assign halted = (state_q == HALT);

  // State register; reset always lands in RUN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control outputs: priority rules evaluated in RUN, and in
  // DWAIT on the cycle the data access completes.
  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b0;
    pc_sel_d     = PC_SEQ;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    flush_inc    = 1'b0;

    if (RST) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN, DWAIT: begin
          if ((state_q == DWAIT) && !dhit) begin
            // Still waiting on data memory: everything frozen.
            state_d = DWAIT;
          end else begin
            state_d = RUN;
            if (halt_mem) begin
              // Let the halt retire into WB, freeze everything upstream.
              mem_wb_en = 1'b1;
              state_d   = HALT;
            end else if ((state_q == RUN) && dmem_req && !dhit) begin
              state_d = DWAIT;
            end else if (branch_taken) begin
              // Branch squashes the three younger instructions, which also
              // covers any load-use or fetch bubble this cycle.
              {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 4'b1111;
              pc_en        = 1'b1;
              pc_sel_d     = PC_BRANCH;
              if_id_flush  = 1'b1;
              id_ex_flush  = 1'b1;
              ex_mem_flush = 1'b1;
              flush_inc    = 1'b1;
            end else if (lu_hazard) begin
              // Hold PC and IF/ID, inject a bubble into ID/EX.
              {id_ex_en, ex_mem_en, mem_wb_en} = 3'b111;
              id_ex_flush = 1'b1;
            end else if (jump_id) begin
              {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 4'b1111;
              pc_en       = 1'b1;
              pc_sel_d    = PC_JUMP;
              if_id_flush = 1'b1;
              flush_inc   = 1'b1;
            end else if (!ihit) begin
              // No fetched instruction: hold PC, bubble into IF/ID.
              {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 4'b1111;
              if_id_flush = 1'b1;
            end else begin
              {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 4'b1111;
              pc_en = 1'b1;
            end
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    stall_inc = !RST && (state_q != HALT) && !pc_en;
  end

  // Performance counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc) stall_count <= stall_count + CNT_W'(1);
      if (flush_inc) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed table, multi-cycle sequences and a
// randomized run against a rule-level reference model.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic       rst, ihit, dhit, dmem, br, jmp, halt, exmr;
    logic [4:0] ex_rd, id_rs, id_rt;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [12:0] exp_o;
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
  } row_t;

  // Packed output layout: {pc_en, pc_sel[1:0], if_id/id_ex/ex_mem/mem_wb en,
  // if_id/id_ex/ex_mem flush, halted, state[1:0]}
  localparam logic [12:0] O_RST_RUN  = 13'b0_00_0000_000_0_00;
  localparam logic [12:0] O_RST_W    = 13'b0_00_0000_000_0_01;
  localparam logic [12:0] O_HALTED   = 13'b0_00_0000_000_1_10;
  localparam logic [12:0] O_FRZ_RUN  = 13'b0_00_0000_000_0_00;
  localparam logic [12:0] O_FRZ_W    = 13'b0_00_0000_000_0_01;
  localparam logic [12:0] O_NORMAL   = 13'b1_00_1111_000_0_00;
  localparam logic [12:0] O_LU       = 13'b0_00_0111_010_0_00;
  localparam logic [12:0] O_BR       = 13'b1_10_1111_111_0_00;
  localparam logic [12:0] O_BR_W     = 13'b1_10_1111_111_0_01;
  localparam logic [12:0] O_JMP      = 13'b1_01_1111_100_0_00;
  localparam logic [12:0] O_NOI      = 13'b0_00_1111_100_0_00;
  localparam logic [12:0] O_HALTIN   = 13'b0_00_0001_000_0_00;
  localparam logic [12:0] O_HALTIN_W = 13'b0_00_0001_000_0_01;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic       ihit, dhit, dmem_req, branch_taken, jump_id, halt_mem, ex_memread;
  logic [4:0] ex_rd, id_rs, id_rt;

  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, halted;
  logic [1:0]  pc_sel, state;
  logic [31:0] stall_count, flush_count;

  logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
  logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_halted;
  logic [1:0]  s_pc_sel, s_state;
  logic [3:0]  s_stall_count, s_flush_count;

  pipeline_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .branch_taken(branch_taken), .jump_id(jump_id), .halt_mem(halt_mem),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .pc_en(pc_en), .pc_sel(pc_sel), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .halted(halted),
    .state(state), .stall_count(stall_count), .flush_count(flush_count)
  );

  // Narrow-counter instance sharing the same stimulus, for wrap behaviour.
  pipeline_ctrl #(.CNT_W(4)) dut_w4 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .branch_taken(branch_taken), .jump_id(jump_id), .halt_mem(halt_mem),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .pc_en(s_pc_en), .pc_sel(s_pc_sel), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en),
    .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en), .if_id_flush(s_if_id_flush),
    .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush), .halted(s_halted),
    .state(s_state), .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  logic [12:0] obs_main, obs_w4;
  assign obs_main = {pc_en, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, ex_mem_flush, halted, state};
  assign obs_w4   = {s_pc_en, s_pc_sel, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en,
                     s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_halted, s_state};

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [12:0] exp_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_now(input string name, input logic [12:0] eo,
                           input logic [31:0] es, input logic [31:0] ef);
    cmp({name, "/ctl"},      {19'd0, obs_main},      {19'd0, eo});
    cmp({name, "/stall"},    stall_count,            es);
    cmp({name, "/flush"},    flush_count,            ef);
    cmp({name, "/ctl_w4"},   {19'd0, obs_w4},        {19'd0, eo});
    cmp({name, "/stall_w4"}, {28'd0, s_stall_count}, {28'd0, es[3:0]});
    cmp({name, "/flush_w4"}, {28'd0, s_flush_count}, {28'd0, ef[3:0]});
  endtask

  // ---------------- reference model ----------------
  int          m_state = 0;   // 0 running, 1 waiting on data, 2 halted
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  function automatic logic [12:0] model_eval(input vec_t v, input int st);
    logic       pe;
    logic [1:0] sel;
    logic [3:0] en;
    logic [2:0] fl;
    logic       lu;
    pe = 1'b0; sel = 2'b00; en = 4'b0000; fl = 3'b000;
    lu = v.exmr && (v.ex_rd != 5'd0) && (v.ex_rd == v.id_rs || v.ex_rd == v.id_rt);
    if (!v.rst && (st == 0 || (st == 1 && v.dhit))) begin
      if (v.halt)                 en = 4'b0001;
      else if (v.dmem && !v.dhit) en = 4'b0000;
      else if (v.br)   begin pe = 1'b1; sel = 2'd2; en = 4'hf; fl = 3'b111; end
      else if (lu)     begin en = 4'b0111; fl = 3'b010; end
      else if (v.jmp)  begin pe = 1'b1; sel = 2'd1; en = 4'hf; fl = 3'b100; end
      else if (!v.ihit) begin en = 4'hf; fl = 3'b100; end
      else             begin pe = 1'b1; en = 4'hf; end
    end
    return {pe, sel, en, fl, (st == 2), 2'(st)};
  endfunction

  task automatic model_advance(input vec_t v, input logic [12:0] o);
    if (v.rst) begin
      m_state = 0; m_stall = '0; m_flush = '0;
    end else if (m_state != 2) begin
      if (!o[12]) m_stall = m_stall + 1;
      if (o[12] && o[11:10] != 2'b00) m_flush = m_flush + 1;
      if (m_state == 1 && !v.dhit)            m_state = 1;
      else if (v.halt)                        m_state = 2;
      else if (m_state == 0 && v.dmem && !v.dhit) m_state = 1;
      else                                    m_state = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic vec_t vin(input logic r, i, d, dm, b, j, h, em,
                               input logic [4:0] rd, rs, rt);
    vec_t v;
    v = '{rst: r, ihit: i, dhit: d, dmem: dm, br: b, jmp: j, halt: h, exmr: em,
          ex_rd: rd, id_rs: rs, id_rt: rt};
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.rst   = ($urandom_range(0, 39) == 0);
    v.ihit  = ($urandom_range(0, 5) != 0);
    v.dhit  = ($urandom_range(0, 2) != 0);
    v.dmem  = ($urandom_range(0, 3) == 0);
    v.br    = ($urandom_range(0, 7) == 0);
    v.jmp   = ($urandom_range(0, 7) == 0);
    v.halt  = ($urandom_range(0, 29) == 0);
    v.exmr  = ($urandom_range(0, 2) == 0);
    v.ex_rd = 5'($urandom_range(0, 3));
    v.id_rs = 5'($urandom_range(0, 3));
    v.id_rt = 5'($urandom_range(0, 3));
    return v;
  endfunction

  // Drive one cycle's inputs on the falling edge, settle before sampling.
  task automatic apply(input vec_t v);
    @(negedge CLK);
    RST = v.rst; ihit = v.ihit; dhit = v.dhit; dmem_req = v.dmem;
    branch_taken = v.br; jump_id = v.jmp; halt_mem = v.halt; ex_memread = v.exmr;
    ex_rd = v.ex_rd; id_rs = v.id_rs; id_rt = v.id_rt;
    #1;
  endtask

  // Apply a vector, compare against the model via the expected queue, advance the model.
  task automatic run_model(input string name, input vec_t v);
    logic [12:0] e;
    apply(v);
    exp_q.push_back(model_eval(v, m_state));
    e = exp_q.pop_front();
    check_now(name, e, m_stall, m_flush);
    model_advance(v, e);
  endtask

  // ---------------- test ----------------
  row_t tbl[27];
  vec_t idle;

  initial begin
    ihit = 1'b0; dhit = 1'b0; dmem_req = 1'b0; branch_taken = 1'b0; jump_id = 1'b0;
    halt_mem = 1'b0; ex_memread = 1'b0; ex_rd = '0; id_rs = '0; id_rt = '0;
    idle = vin(0,1,0,0,0,0,0,0,0,0,0);

    tbl[0]  = '{vin(1,1,0,0,0,0,0,0,0,0,0), O_RST_RUN,  0, 0};
    tbl[1]  = '{vin(1,0,0,0,0,0,0,0,0,0,0), O_RST_RUN,  0, 0};
    tbl[2]  = '{idle,                       O_NORMAL,   0, 0};
    tbl[3]  = '{vin(0,1,0,0,0,0,0,1,8,0,8), O_LU,       0, 0};
    tbl[4]  = '{vin(0,1,0,0,0,0,0,1,0,0,0), O_NORMAL,   1, 0};
    tbl[5]  = '{vin(0,1,0,0,0,0,0,1,5,5,3), O_LU,       1, 0};
    tbl[6]  = '{vin(0,1,0,0,0,0,0,0,5,5,3), O_NORMAL,   2, 0};
    tbl[7]  = '{vin(0,1,0,0,1,0,0,1,8,0,8), O_BR,       2, 0};
    tbl[8]  = '{vin(0,0,0,0,1,0,0,0,0,0,0), O_BR,       2, 1};
    tbl[9]  = '{vin(0,1,0,0,0,1,0,0,0,0,0), O_JMP,      2, 2};
    tbl[10] = '{vin(0,0,0,0,0,0,0,0,0,0,0), O_NOI,      2, 3};
    tbl[11] = '{vin(0,0,0,0,0,1,0,0,0,0,0), O_JMP,      3, 3};
    tbl[12] = '{vin(0,1,0,0,0,1,0,1,7,7,0), O_LU,       3, 4};
    tbl[13] = '{vin(0,1,1,1,0,0,0,0,0,0,0), O_NORMAL,   4, 4};
    tbl[14] = '{vin(0,1,0,1,1,0,0,0,0,0,0), O_FRZ_RUN,  4, 4};
    tbl[15] = '{vin(0,1,0,1,1,0,0,0,0,0,0), O_FRZ_W,    5, 4};
    tbl[16] = '{vin(0,1,1,1,1,0,0,0,0,0,0), O_BR_W,     6, 4};
    tbl[17] = '{idle,                       O_NORMAL,   6, 5};
    tbl[18] = '{vin(0,1,0,1,0,0,0,0,0,0,0), O_FRZ_RUN,  6, 5};
    tbl[19] = '{vin(1,1,0,1,0,0,0,0,0,0,0), O_RST_W,    7, 5};
    tbl[20] = '{idle,                       O_NORMAL,   0, 0};
    tbl[21] = '{vin(0,1,0,1,0,0,0,0,0,0,0), O_FRZ_RUN,  0, 0};
    tbl[22] = '{vin(0,1,0,1,0,0,1,0,0,0,0), O_FRZ_W,    1, 0};
    tbl[23] = '{vin(0,1,1,1,0,0,1,0,0,0,0), O_HALTIN_W, 2, 0};
    tbl[24] = '{vin(0,1,0,0,1,0,0,0,0,0,0), O_HALTED,   3, 0};
    tbl[25] = '{vin(1,1,0,0,0,0,0,0,0,0,0), O_HALTED,   3, 0};
    tbl[26] = '{idle,                       O_NORMAL,   0, 0};

    // One edge under reset so registered state is defined before the first check.
    @(posedge CLK);

    for (int i = 0; i < 27; i++) begin
      logic [12:0] mo;
      apply(tbl[i].v);
      check_now($sformatf("tbl%0d", i), tbl[i].exp_o, tbl[i].exp_stall, tbl[i].exp_flush);
      mo = model_eval(tbl[i].v, m_state);
      model_advance(tbl[i].v, mo);
    end

    // Data-memory wait: three cycles without dhit, then dhit.
    for (int i = 0; i < 3; i++) run_model($sformatf("dwait_frz%0d", i), vin(0,1,0,1,0,0,0,0,0,0,0));
    cmp("dwait_state_frozen", {30'd0, state}, 32'd1);
    run_model("dwait_hit", vin(0,1,1,1,0,0,0,0,0,0,0));
    cmp("dwait_hit_en", {28'd0, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 32'hf);
    run_model("dwait_after", idle);
    cmp("dwait_state_after", {30'd0, state}, 32'd0);
    cmp("dwait_stall_total", stall_count, 32'd3);

    // Halt from RUN, then five cycles of arbitrary non-reset inputs, then reset.
    run_model("halt_entry", vin(0,1,0,0,0,0,1,0,0,0,0));
    cmp("halt_entry_ctl", {19'd0, obs_main}, {19'd0, O_HALTIN});
    for (int i = 0; i < 5; i++) begin
      vec_t v;
      v = rand_vec();
      v.rst = 1'b0;
      run_model($sformatf("halt_hold%0d", i), v);
      cmp($sformatf("halt_hold%0d_ctl", i), {19'd0, obs_main}, {19'd0, O_HALTED});
    end
    cmp("halt_stall_hold", stall_count, 32'd4);
    run_model("halt_rst", vin(1,0,0,0,0,0,0,0,0,0,0));
    run_model("halt_exit", idle);
    cmp("halt_exit_state", {30'd0, state}, 32'd0);

    // Counter wrap: 17 load-use stalls on a fresh count.
    run_model("wrap_rst", vin(1,1,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 17; i++) run_model($sformatf("wrap_lu%0d", i), vin(0,1,0,0,0,0,0,1,9,9,2));
    run_model("wrap_after", idle);
    cmp("wrap_w4_stall", {28'd0, s_stall_count}, 32'd1);
    cmp("wrap_w32_stall", stall_count, 32'd17);

    // Randomized run from a clean reset.
    run_model("rand_rst", vin(1,1,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 600; i++) run_model($sformatf("rand%0d", i), rand_vec());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
